alu_slice_seq: RTL and testbench
================================

# alu_slice_seq

Word-serial sequencer that drives the 2-bit slice ALU. It accepts a W-bit operand pair plus a 3-bit opcode through a valid/ready handshake. It then presents the operands to the ALU two bits per cycle, LSB slice first, and collects the slice results into a W-bit result with equality and carry flags. A second valid/ready handshake delivers the result downstream. It sits directly upstream of the ALU, owns all of the ALU's inputs, and consumes all of its outputs.

## Interface
- W, default 8: operand/result width; even, ≥ 2. SLICES = W/2.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_a, in_b  in  W  operands
- in_op  in  3  opcode {o1,o2,o3} = {in_op[2],in_op[1],in_op[0]}
- alu_a0, alu_b0, alu_a1, alu_b1  out  1 each  current slice bits to ALU
- alu_o1, alu_o2, alu_o3  out  1 each  opcode to ALU
- alu_c0, alu_c1, alu_c2, alu_c3  in  1 each  ALU result bit 0, bit 1, carry, slice-equal
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_res  out  W  concatenated slice results
- out_eq  out  1  AND of alu_c3 over all slices
- out_cy  out  1  alu_c2 of the final (MS) slice

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture in_a, in_b, in_op; clear cnt, res, eq:=1; go to RUN.
  - RUN: in_ready=0. Drive slice cnt from the captured operands: alu_a0=a[2cnt], alu_a1=a[2cnt+1], same for b. Drive alu_o* from the captured op. Each clock:
    - res[2cnt+1:2cnt] := {alu_c1, alu_c0}
    - eq := eq & alu_c3
    - if cnt==SLICES-1: cy := alu_c2, go to DONE; else cnt+1.
  - DONE: out_valid=1, out_res/out_eq/out_cy stable. On out_ready go to IDLE.
- No inter-slice carry. Each slice is evaluated independently; out_cy reflects the MS slice only.
- ALU inputs are all 0 outside RUN. The opcode and operands are held constant for the whole RUN.
- in_valid is ignored outside IDLE; new inputs never disturb an operation in flight.
- out_res, out_eq and out_cy hold their last value while in IDLE; only out_valid qualifies them.
- cnt width is clog2(SLICES), minimum 1. cnt never exceeds SLICES-1.

## Timing
- Reset: state=IDLE, cnt=0, and every output is 0 except in_ready=1. This includes out_res, out_eq, out_cy, out_valid and all alu_*.
- Reset during RUN or DONE aborts without emitting a result. The next cycle is IDLE.
- Accept at edge T0. RUN occupies cycles T0+1 … T0+SLICES. out_valid rises at T0+SLICES+1.
- With out_ready held at 1:
  - DONE lasts 1 cycle and in_ready returns at T0+SLICES+2.
  - Minimum spacing between accepts is SLICES+2 cycles (6 for W=8).
- The ALU path is combinational and must settle within one cycle. The ALU outputs are sampled on the same edge that advances cnt.
- Simultaneous rst and in_valid: rst wins; nothing is captured.

## Structure
- Shared package contents:
  - state enum {IDLE, RUN, DONE}
  - opcode localparam OP_CARRY = 3'b111, the only op for which the ALU reports carry.
- One sub-module is natural: alu_slice_mux, a combinational selector of the cnt-th 2-bit slice from a W-bit vector, instantiated once each for a and b.
- The FSM, result shift/insert, and flag registers stay in the top module.

## Test plan
The bench uses a behavioural ALU stub: c0=a0^b0, c1=a1^b1, c2=a1&b1&o1&o2&o3, c3=(a0==b0)&(a1==b1). W=8 throughout.

- **Basic op:** in_a=0xB4, in_b=0x3C, in_op=000 → out_res=0x88, out_eq=0, out_cy=0; out_valid exactly 5 cycles after accept.
- **Equal operands, carry op:** in_a=in_b=0xC5, in_op=111 → out_res=0x00, out_eq=1, out_cy=1.
- **Backpressure:** out_ready=0 for 10 cycles → out_valid and outputs stable and in_ready=0 throughout; a second in_valid is not accepted until the cycle after out_ready=1.
- **Back-to-back:** in_valid and out_ready held at 1 with three requests → accepts exactly every 6 cycles; results in order.
- **Reset mid-RUN:** rst on the 2nd RUN cycle → next cycle IDLE, out_valid=0, all alu_*=0; no stale result appears afterwards.
- **Slice order:** in_a=0x01, in_b=0x00 → the first RUN cycle drives alu_a0=1; the following cycles drive alu_a0=0.

Source files
------------

// File: rtl/alu_slice_seq_pkg.sv
// rtl/alu_slice_seq_pkg.sv - shared types and constants for the slice ALU sequencer
// Purpose: FSM state encoding, carry opcode and counter sizing helper.
package alu_slice_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The ALU only reports carry for this opcode.
    localparam logic [2:0] OP_CARRY = 3'b111;

    // Slice counter width; a single-slice datapath still needs one bit.
    function automatic int cnt_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/alu_slice_seq_if.sv
// rtl/alu_slice_seq_if.sv - request/result/ALU signal bundle for the sequencer
// Purpose: groups the request handshake, result handshake and ALU pins.
// Modports:
//   master - environment: drives requests, consumes results, plays the ALU
//   slave  - sequencer:   accepts requests, produces results, drives the ALU
interface alu_slice_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;

    logic         alu_a0, alu_b0, alu_a1, alu_b1;
    logic         alu_o1, alu_o2, alu_o3;
    logic         alu_c0, alu_c1, alu_c2, alu_c3;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_eq;
    logic         out_cy;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        output alu_c0, alu_c1, alu_c2, alu_c3,
        input  in_ready, out_valid, out_res, out_eq, out_cy,
        input  alu_a0, alu_b0, alu_a1, alu_b1, alu_o1, alu_o2, alu_o3
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        input  alu_c0, alu_c1, alu_c2, alu_c3,
        output in_ready, out_valid, out_res, out_eq, out_cy,
        output alu_a0, alu_b0, alu_a1, alu_b1, alu_o1, alu_o2, alu_o3
    );

endinterface

// File: rtl/alu_slice_seq_mux.sv
// rtl/alu_slice_seq_mux.sv - selects the sel-th 2-bit slice of a W-bit vector
// Ports:
//   vec_i   W-bit source vector
//   sel_i   slice index (0 = least significant pair)
//   slice_o selected 2-bit slice
module alu_slice_mux #(
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic [W-1:0]  vec_i,
    input  logic [CW-1:0] sel_i,
    output logic [1:0]    slice_o
);

    always_comb begin
        slice_o = 2'b00;
        for (int i = 0; i < W / 2; i++) begin
            if (sel_i == CW'(i)) begin
                slice_o = vec_i[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/alu_slice_seq.sv
// rtl/alu_slice_seq.sv - word-serial sequencer feeding a 2-bit slice ALU
// Purpose: accepts an operand pair and opcode, walks the ALU over SLICES
// 2-bit slices LSB first, assembles the result word plus eq/carry flags.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       slave view of alu_slice_seq_if (request, result, ALU pins)
module alu_slice_seq
    import alu_slice_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_slice_seq_if.slave  bus
);

    localparam int SLICES = W / 2;
    localparam int CW     = cnt_width(SLICES);
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q, b_q;
    logic [2:0]    op_q;
    logic [W-1:0]  res_q, res_d;
    logic          eq_q, cy_q;
    logic          in_ready_q, out_valid_q;

    logic [1:0]    a_sl, b_sl;
    logic          run;

    alu_slice_mux #(.W(W), .CW(CW)) u_mux_a (.vec_i(a_q), .sel_i(cnt_q), .slice_o(a_sl));
    alu_slice_mux #(.W(W), .CW(CW)) u_mux_b (.vec_i(b_q), .sel_i(cnt_q), .slice_o(b_sl));

    // Drop the ALU's slice result into position cnt of the accumulator.
    always_comb begin
        res_d = res_q;
        for (int i = 0; i < SLICES; i++) begin
            if (cnt_q == CW'(i)) begin
                res_d[2*i +: 2] = {bus.alu_c1, bus.alu_c0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            eq_q        <= 1'b0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        op_q       <= bus.in_op;
                        cnt_q      <= '0;
                        res_q      <= '0;
                        eq_q       <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    eq_q  <= eq_q & bus.alu_c3;
                    if (cnt_q == LAST) begin
                        // Slices are independent; only the MS slice carry survives.
                        cy_q        <= bus.alu_c2;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ALU pins are forced low whenever no slice is being evaluated.
    assign run        = (state_q == RUN);
    assign bus.alu_a0 = run & a_sl[0];
    assign bus.alu_a1 = run & a_sl[1];
    assign bus.alu_b0 = run & b_sl[0];
    assign bus.alu_b1 = run & b_sl[1];
    assign bus.alu_o1 = run & op_q[2];
    assign bus.alu_o2 = run & op_q[1];
    assign bus.alu_o3 = run & op_q[0];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_eq    = eq_q;
    assign bus.out_cy    = cy_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// tb/tb_alu_slice_seq.sv - self-checking bench for alu_slice_seq with ALU stub
module tb_alu_slice_seq;
    import alu_slice_seq_pkg::*;

    localparam int W = 8;
    localparam int SL = W / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    alu_slice_seq_if #(.W(W)) bus ();

    alu_slice_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU stub
    assign bus.alu_c0 = bus.alu_a0 ^ bus.alu_b0;
    assign bus.alu_c1 = bus.alu_a1 ^ bus.alu_b1;
    assign bus.alu_c2 = bus.alu_a1 & bus.alu_b1 & bus.alu_o1 & bus.alu_o2 & bus.alu_o3;
    assign bus.alu_c3 = (bus.alu_a0 == bus.alu_b0) & (bus.alu_a1 == bus.alu_b1);

    typedef struct packed {
        logic [W-1:0] res;
        logic         eq;
        logic         cy;
    } rslt_t;

    // Word-level view of the whole operation with the stub ALU.
    function automatic rslt_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        rslt_t r;
        r.res = a ^ b;
        r.eq  = (a == b);
        r.cy  = a[W-1] & b[W-1] & (op == OP_CARRY);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    bit           chk_en = 0;
    bit           m_busy = 0;
    int           m_acc = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2:0]   m_op = '0;
    rslt_t        m_cur = '0, m_last = '0;
    int           n_results = 0;

    always @(negedge clk) begin
        int e;
        int k;
        if (chk_en) begin
            e = cyc - m_acc;
            k = e - 1;
            chk("in_ready", bus.in_ready, !m_busy);
            chk("out_valid", bus.out_valid, m_busy && e > SL);
            if (m_busy && e >= 1 && e <= SL) begin
                chk("alu_a", {bus.alu_a1, bus.alu_a0}, {m_a[2*k+1], m_a[2*k]});
                chk("alu_b", {bus.alu_b1, bus.alu_b0}, {m_b[2*k+1], m_b[2*k]});
                chk("alu_op", {bus.alu_o1, bus.alu_o2, bus.alu_o3}, m_op);
            end else begin
                chk("alu_quiet", {bus.alu_a0, bus.alu_b0, bus.alu_a1, bus.alu_b1,
                                  bus.alu_o1, bus.alu_o2, bus.alu_o3}, 0);
            end
            if (m_busy && e > SL)
                chk("result", {bus.out_res, bus.out_eq, bus.out_cy}, m_cur);
            else if (!m_busy)
                chk("held", {bus.out_res, bus.out_eq, bus.out_cy}, m_last);
        end
        if (rst) begin
            m_busy = 0;
            m_last = '0;
        end else if (!m_busy && bus.in_valid) begin
            m_busy = 1;
            m_acc  = cyc;
            m_a    = bus.in_a;
            m_b    = bus.in_b;
            m_op   = bus.in_op;
            m_cur  = model(bus.in_a, bus.in_b, bus.in_op);
        end else if (m_busy && (cyc - m_acc) > SL && bus.out_ready) begin
            m_busy = 0;
            m_last = m_cur;
            n_results++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, output int acc);
        bit got;
        got = 0;
        acc = -1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_op = op;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                acc = cyc;
            end
        end
        if (!got) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vc, output rslt_t r);
        bit got;
        got = 0;
        vc = -1;
        r = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                vc = cyc;
                r = {bus.out_res, bus.out_eq, bus.out_cy};
            end
        end
        if (!got) chk("valid_timeout", 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int    acc, vc, hs, n0, idx, nv;
        int    acc_c[3];
        rslt_t r;
        logic [W-1:0] ba[3], bb[3];
        logic [2:0]   bo[3];
        bit got;

        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = '0;
        bus.out_ready = 1'b1;

        // model pinning
        chk("model_basic", model(8'hB4, 8'h3C, 3'b000), {8'h88, 1'b0, 1'b0});
        chk("model_carry", model(8'hC5, 8'hC5, 3'b111), {8'h00, 1'b1, 1'b1});

        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_outs", {bus.out_valid, bus.out_res, bus.out_eq, bus.out_cy}, 0);
        chk("rst_alu", {bus.alu_a0, bus.alu_b0, bus.alu_a1, bus.alu_b1,
                        bus.alu_o1, bus.alu_o2, bus.alu_o3}, 0);

        // basic op + latency
        send(8'hB4, 8'h3C, 3'b000, acc);
        wait_valid(vc, r);
        chk("basic_latency", vc - acc, 5);
        chk("basic_res", {r.res, r.eq, r.cy}, {8'h88, 1'b0, 1'b0});

        // equal operands, carry op
        send(8'hC5, 8'hC5, OP_CARRY, acc);
        wait_valid(vc, r);
        chk("carry_res", {r.res, r.eq, r.cy}, {8'h00, 1'b1, 1'b1});

        // backpressure
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(8'h5A, 8'hA5, 3'b011, acc);
        wait_valid(vc, r);
        chk("bp_res", {r.res, r.eq, r.cy}, {8'hFF, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a = 8'h11;
        bus.in_b = 8'h22;
        bus.in_op = 3'b111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_res}, {1'b1, 1'b0, 8'hFF});
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                chk("bp_reaccept", cyc - hs, 1);
            end
        end
        if (!got) chk("bp_reaccept_timeout", 0, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        wait_valid(vc, r);
        chk("bp_second", {r.res, r.eq, r.cy}, {8'h33, 1'b0, 1'b0});

        // back-to-back
        ba[0] = 8'h12; bb[0] = 8'h34; bo[0] = 3'b111;
        ba[1] = 8'hF0; bb[1] = 8'hF0; bo[1] = 3'b111;
        ba[2] = 8'h80; bb[2] = 8'h81; bo[2] = 3'b110;
        @(negedge clk);
        n0 = n_results;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a = ba[0]; bus.in_b = bb[0]; bus.in_op = bo[0];
        idx = 0;
        for (int i = 0; i < 100 && idx < 3; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_c[idx] = cyc;
                idx++;
                @(posedge clk); #1;
                if (idx < 3) begin
                    bus.in_a = ba[idx]; bus.in_b = bb[idx]; bus.in_op = bo[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        if (idx < 3) chk("b2b_timeout", idx, 3);
        else begin
            chk("b2b_gap1", acc_c[1] - acc_c[0], 6);
            chk("b2b_gap2", acc_c[2] - acc_c[1], 6);
        end
        repeat (8) @(negedge clk);
        chk("b2b_count", n_results - n0, 3);

        // reset mid-RUN
        send(8'hFF, 8'h0F, 3'b111, acc);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        chk("midrst_alu", {bus.alu_a0, bus.alu_b0, bus.alu_a1, bus.alu_b1,
                           bus.alu_o1, bus.alu_o2, bus.alu_o3}, 0);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        chk("midrst_no_result", nv, 0);

        // slice order
        send(8'h01, 8'h00, 3'b000, acc);
        for (int j = 0; j < SL; j++) begin
            @(negedge clk);
            chk($sformatf("slice_a0_%0d", j), bus.alu_a0, (j == 0));
        end
        wait_valid(vc, r);
        chk("slice_res", r.res, 8'h01);

        // randomized traffic with random backpressure and in_valid noise
        for (int t = 0; t < 40; t++) begin
            send(W'($urandom), W'($urandom), 3'($urandom), acc);
            got = 0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(posedge clk); #1;
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
                @(negedge clk);
                if (bus.out_valid && bus.out_ready) got = 1;
            end
            if (!got) chk("rand_timeout", 0, 1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
